// File: rtl/cpu_sequencer.sv
// cpu_sequencer: non-pipelined fetch/decode/read/exec/writeback controller driving a
// 16x16 register file and a start/done ALU. Define WATCHDOG_EN to add the ALU watchdog.
module cpu_sequencer #(
  parameter int PC_W = 8
`ifdef WATCHDOG_EN
  , parameter int WDOG_MAX = 15
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic            rf_en,
  output logic [1:0]      rf_rw,
  output logic [3:0]      rf_da,
  output logic [3:0]      rf_aa,
  output logic [3:0]      rf_ba,
  output logic [15:0]     rf_d,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [15:0]     alu_result,
  output logic            halted,
  output logic            illegal,
  output logic            timeout
);

  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_MOV    = 4'h6;
  localparam logic [3:0] OP_LDI    = 4'h7;
  localparam logic [3:0] OP_JMP    = 4'h8;
  localparam logic [3:0] OP_ILL_LO = 4'h9;
  localparam logic [3:0] OP_ILL_HI = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
  endfunction

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     wb_q, wb_d;
  logic            illegal_q, illegal_d;
  logic            exec_first_q, exec_first_d;
  logic [3:0]      op_s;

  assign op_s = instr_q[15:12];

`ifdef WATCHDOG_EN
  localparam logic [3:0] WDOG_LIM = 4'(WDOG_MAX);

  logic [3:0] wdog_q, wdog_d;
  logic [3:0] wdog_inc_s;
  logic       timeout_q, timeout_d;

  assign wdog_inc_s = wdog_q + 4'd1;

  // Watchdog counter: cleared on the way into EXEC, counts EXEC cycles without alu_done.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_READ) begin
      wdog_d = 4'd0;
    end else if ((state_q == S_EXEC) && !alu_done) begin
      wdog_d = wdog_inc_s;
    end else begin
      wdog_d = wdog_q;
    end
  end
`endif

  // Next-state logic for the sequencer and its latched instruction/data registers.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wb_d         = wb_q;
    illegal_d    = illegal_q;
    exec_first_d = 1'b0;
`ifdef WATCHDOG_EN
    timeout_d    = timeout_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_alu_op(op_s)) begin
          state_d = S_READ;
        end else if (op_s == OP_LDI) begin
          wb_d    = {8'h00, instr_q[7:0]};
          state_d = S_WB;
        end else if (op_s == OP_JMP) begin
          // JMP replaces the increment already applied at fetch.
          pc_d    = PC_W'(instr_q[7:0]);
          state_d = S_FETCH;
        end else if (op_s == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          illegal_d = illegal_q | is_illegal_op(op_s);
          state_d   = S_FETCH;
        end
      end
      S_READ: begin
        exec_first_d = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        if (alu_done) begin
          wb_d    = alu_result;
          state_d = S_WB;
`ifdef WATCHDOG_EN
        end else if (wdog_inc_s == WDOG_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      instr_q      <= 16'h0000;
      wb_q         <= 16'h0000;
      illegal_q    <= 1'b0;
      exec_first_q <= 1'b0;
`ifdef WATCHDOG_EN
      wdog_q       <= 4'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wb_q         <= wb_d;
      illegal_q    <= illegal_d;
      exec_first_q <= exec_first_d;
`ifdef WATCHDOG_EN
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Strobes decoded from state; the enables are held low while rst is asserted.
  always_comb begin
    instr_ready = 1'b0;
    rf_en       = 1'b0;
    rf_rw       = RW_IDLE;
    alu_start   = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = ~rst;
      end
      S_READ: begin
        rf_en = ~rst;
        rf_rw = RW_READ;
      end
      S_EXEC: begin
        alu_start = exec_first_q & ~rst;
      end
      S_WB: begin
        rf_en = ~rst;
        rf_rw = RW_WRITE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  assign pc      = pc_q;
  assign rf_da   = instr_q[11:8];
  assign rf_aa   = instr_q[7:4];
  assign rf_ba   = instr_q[3:0];
  assign rf_d    = wb_q;
  assign alu_op  = op_s;
  assign illegal = illegal_q;

`ifdef WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected register-file reads/writes are queued
// by the stimulus and popped by a negedge monitor; latency and status are checked inline.
module tb_cpu_sequencer;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [15:0]     instr;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic            rf_en;
  logic [1:0]      rf_rw;
  logic [3:0]      rf_da, rf_aa, rf_ba;
  logic [15:0]     rf_d;
  logic [3:0]      alu_op;
  logic            alu_start;
  logic            alu_done;
  logic [15:0]     alu_result;
  logic            halted, illegal, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int alu_lat = 0;
  logic [15:0] alu_val = 16'h0000;

  logic [19:0] wr_q[$];  // {da, data}
  logic [7:0]  rd_q[$];  // {aa, ba}

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .pc(pc), .rf_en(rf_en), .rf_rw(rf_rw),
    .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_d(rf_d),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .halted(halted), .illegal(illegal), .timeout(timeout)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every register-file access must match the head of its queue.
  always @(negedge clk) begin
    if (rf_en === 1'b1 && rf_rw === 2'b01) begin
      if (wr_q.size() == 0) check("unexpected_write", {rf_da, rf_d}, 64'hDEAD_0000_0000_0000);
      else check("rf_write", {rf_da, rf_d}, wr_q.pop_front());
    end
    if (rf_en === 1'b1 && rf_rw === 2'b10) begin
      if (rd_q.size() == 0) check("unexpected_read", {rf_aa, rf_ba}, 64'hDEAD_0000_0000_0000);
      else check("rf_read", {rf_aa, rf_ba}, rd_q.pop_front());
    end
  end

  // ALU model: raises alu_done alu_lat EXEC cycles after the start pulse, unless abandoned.
  always @(negedge clk) begin : alu_model
    int w;
    if (alu_start === 1'b1) begin
      start_cnt++;
      w = 0;
      while (w < alu_lat && instr_ready !== 1'b1) begin
        @(negedge clk);
        w++;
      end
      if (instr_ready !== 1'b1) begin
        alu_done   = 1'b1;
        alu_result = alu_val;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
      end
    end
  end

  task automatic issue(input logic [15:0] w);
    int k;
    instr = w;
    instr_valid = 1'b1;
    k = 0;
    while (instr_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("issue_ready_timeout", 64'(k), 64'd0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && k < 200) begin
      k++;
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [15:0] w, input string nm, input int exp_lat);
    int k;
    issue(w);
    wait_ready(k);
    check({nm, "_latency"}, 64'(k), 64'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k, s0, bad;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    alu_done = 1'b0; alu_result = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {pc, rf_rw, rf_da, rf_aa, rf_ba, rf_d, alu_op,
          halted, illegal, timeout, rf_en, alu_start, instr_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(instr_ready), 64'd1);

    // LDI R3 <= 0x12
    wr_q.push_back({4'h3, 16'h0012});
    run(16'h7312, "ldi", 2);
    check("pc_after_ldi", 64'(pc), 64'h01);

    // ADD R1 <= R2+R3, done in third EXEC cycle
    rd_q.push_back({4'h2, 4'h3});
    wr_q.push_back({4'h1, 16'hBEEF});
    alu_lat = 2; alu_val = 16'hBEEF; s0 = start_cnt;
    run(16'h1123, "add", 6);
    check("add_start_pulses", 64'(start_cnt - s0), 64'd1);
    check("add_alu_op", 64'(alu_op), 64'h1);

    // Walk pc to 5, then JMP 0xFE and wrap
    run(16'h0000, "nop", 1);
    run(16'h0000, "nop", 1);
    run(16'h0000, "nop", 1);
    check("pc_before_jmp", 64'(pc), 64'h05);
    run(16'h80FE, "jmp", 1);
    check("pc_after_jmp", 64'(pc), 64'hFE);
    run(16'h0000, "nop", 1);
    run(16'h0000, "nop", 1);
    check("pc_wrap", 64'(pc), 64'h00);

    // Illegal opcode then a normal LDI
    run(16'hA123, "illegal_op", 1);
    check("illegal_set", 64'(illegal), 64'd1);
    wr_q.push_back({4'h5, 16'h00AB});
    run(16'h75AB, "ldi_after_ill", 2);
    check("illegal_sticky", 64'(illegal), 64'd1);

    // XOR with alu_done in the first EXEC cycle
    rd_q.push_back({4'hD, 4'hE});
    wr_q.push_back({4'hC, 16'h0F0F});
    alu_lat = 0; alu_val = 16'h0F0F;
    run(16'h5CDE, "xor", 4);

    // Slow ALU: 25 wait cycles
    rd_q.push_back({4'h5, 4'h6});
    alu_lat = 25; alu_val = 16'h1234; s0 = start_cnt;
`ifdef WATCHDOG_EN
    run(16'h2456, "wdog", 17);
    check("timeout_set", 64'(timeout), 64'd1);
`else
    wr_q.push_back({4'h4, 16'h1234});
    issue(16'h2456);
    repeat (20) @(negedge clk);
    check("slow_still_busy", {instr_ready, timeout}, 64'd0);
    wait_ready(k);
    check("slow_latency", 64'(k + 20), 64'd29);
`endif
    check("slow_start_pulses", 64'(start_cnt - s0), 64'd1);

    // rst during EXEC abandons the instruction
    rd_q.push_back({4'h8, 4'h9});
    alu_lat = 1000;
    issue(16'h3789);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_exec", {pc, rf_rw, rf_da, rf_aa, rf_ba, rf_d, alu_op,
          halted, illegal, timeout, rf_en, alu_start, instr_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("fetch_after_rst", {instr_ready, pc}, {1'b1, 8'h00});
    wr_q.push_back({4'hE, 16'h0055});
    run(16'h7E55, "ldi_post_rst", 2);

    // HALT ignores further instructions until rst
    issue(16'hF000);
    instr = 16'h7111; instr_valid = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready !== 1'b0 || halted !== 1'b1) bad++;
    end
    check("halt_hold_cycles", 64'(bad), 64'd0);
    check("halt_pc", 64'(pc), 64'h02);
    @(posedge clk); #1; rst = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", {halted, instr_ready, pc}, {1'b0, 1'b1, 8'h00});

    repeat (2) @(negedge clk);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer that sits directly upstream of the 16-bit, 16-entry register file. It fetches 16-bit instruction words over a valid/ready handshake and decodes them. It sequences the register file through read and write phases (EN, RW, DA/AA/BA, D) and hands operands to the ALU through a start/done handshake. One instruction is in flight at a time; there is no pipelining.

## Interface
Parameters:
- PC_W, 8, program counter width
- WDOG_MAX, 15, watchdog limit in EXEC cycles (used only with WATCHDOG_EN)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction word available
- instr  in  16  instruction: [15:12] opcode, [11:8] DA, [7:4] AA, [3:0] BA / imm8 = [7:0]
- instr_ready  out  1  sequencer accepts instruction this cycle
- pc  out  PC_W  address of the next instruction to fetch
- rf_en  out  1  register file enable
- rf_rw  out  2  register file {RD,WR}: 10 = read, 01 = write, 00 = idle
- rf_da, rf_aa, rf_ba  out  4 each  register file addresses
- rf_d  out  16  register file write data
- alu_op  out  4  opcode passed to the ALU
- alu_start  out  1  one-cycle ALU start pulse
- alu_done  in  1  ALU result valid
- alu_result  in  16  ALU result
- halted  out  1  HALT executed
- illegal  out  1  sticky: undefined opcode seen
- timeout  out  1  sticky: ALU watchdog expired

## Operation
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR, 0x6 MOV are ALU ops: R[DA] <= f(R[AA], R[BA]).
  - 0x7 LDI: R[DA] <= {8'h00, imm8}.
  - 0x8 JMP: pc <= imm8, zero-extended or truncated to PC_W.
  - 0xF HALT.
  - 0x9–0xE are illegal: they set `illegal` and then execute as NOP.
- States and transitions:
  - FETCH: instr_ready=1. On instr_valid & instr_ready, latch instr, pc <= pc+1, go to DECODE.
  - DECODE: ALU op goes to READ. LDI goes to WB. JMP loads pc and goes to FETCH. NOP/illegal go to FETCH. HALT goes to HALT.
  - READ: rf_en=1, rf_rw=10. The register file captures A/B at the closing edge. Go to EXEC.
  - EXEC: alu_start=1 in the first EXEC cycle only. alu_done is sampled in every EXEC cycle, including the first. On alu_done, latch alu_result into the WB data register and go to WB.
  - WB: rf_en=1, rf_rw=01, rf_d = latched data (ALU result or LDI immediate). Go to FETCH.
  - HALT: halted=1, instr_ready=0. The sequencer stays in HALT until rst.
- rf_da/rf_aa/rf_ba/alu_op are driven from the latched instruction in every state.
- rf_en=0 and rf_rw=00 in every state except READ and WB.
- pc wraps modulo 2^PC_W (0xFF+1 = 0x00). JMP overrides the increment made at fetch.
- Outputs are decoded from state plus latched registers. While rst=1, instr_ready, rf_en and alu_start are forced to 0.
- Reset values (after a rst edge):
  - state FETCH.
  - pc, rf_rw, rf_da/aa/ba, rf_d, alu_op all 0.
  - halted, illegal, timeout all 0.
  - rf_en and alu_start 0.
- rst mid-instruction abandons it: no write occurs and the next cycle is FETCH with pc=0.

## Timing
- Handshake completes on the edge where instr_valid & instr_ready are both 1.
  - instr_valid may be held high across instructions.
  - instr must stay stable while instr_valid=1 and ready=0.
- ALU op with alu_done in the first EXEC cycle: DECODE, READ, EXEC, WB. instr_ready returns 4 cycles after the handshake edge. Each extra alu_done wait cycle adds 1.
- LDI: DECODE, WB; ready returns after 2 cycles.
- JMP/NOP/illegal: DECODE only; ready returns after 1 cycle.
- Exactly one rf write per ALU/LDI instruction. alu_start is never asserted twice for the same instruction.

## Configuration
- WATCHDOG_EN defined:
  - A 4-bit counter clears on entry to EXEC and increments each EXEC cycle without alu_done.
  - When the counter reaches WDOG_MAX: set `timeout` (sticky), skip WB, go to FETCH.
  - If alu_done arrives in the same cycle the counter reaches WDOG_MAX, alu_done wins.
- WATCHDOG_EN undefined: EXEC waits indefinitely and `timeout` is tied to 0.

## Test plan
- Reset, then LDI 0x7312 → WB cycle shows rf_en=1, rf_rw=01, rf_da=3, rf_d=0x0012. instr_ready returns 2 cycles after the handshake and pc=1.
- ADD 0x1123 with alu_done held 3 EXEC cycles, alu_result=0xBEEF:
  - one READ cycle with rf_aa=2, rf_ba=3, rf_rw=10.
  - a single alu_start pulse.
  - WB writes 0xBEEF to R1.
  - ready returns 6 cycles after the handshake.
- JMP 0x80FE from pc=5 → next fetch at pc=0xFE. Two NOPs later pc=0x00 (wrap).
- Opcode 0xA → illegal=1, no rf_en pulse, the following instruction executes normally.
- HALT 0xF000 → halted=1 and instr_ready=0 for 20 cycles despite instr_valid=1. rst clears to FETCH with pc=0.
- WATCHDOG_EN with alu_done never asserted → timeout=1 after 15 EXEC cycles, no WB write, FETCH resumes. Also: rst asserted during EXEC → no write, all outputs at reset values.
